// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared types and helpers for the LED pattern generator
package led_pattern_pkg;

    // Per-channel pattern selection as presented on i_mode.
    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_BURST = 2'b11
    } led_mode_t;

    // Per-channel FSM states; S_HI/S_LO form blink, S_BHI/S_BLO/S_GAP form burst.
    typedef enum logic [2:0] {
        S_OFF = 3'd0,
        S_ON  = 3'd1,
        S_HI  = 3'd2,
        S_LO  = 3'd3,
        S_BHI = 3'd4,
        S_BLO = 3'd5,
        S_GAP = 3'd6
    } led_state_t;

    // Prescaler divide ratio; callers must keep the result at 2 or more.
    function automatic int calc_div(input int clk_value, input int tick_hz);
        return clk_value / tick_hz;
    endfunction

endpackage

// File: rtl/led_pattern_channel.sv
// rtl/led_pattern_channel.sv - one LED channel: config latch, phase counters and pattern FSM (optional LED_PATTERN_SYNC_EN)
module led_pattern_channel
    import led_pattern_pkg::*;
#(
    parameter int HP_W     = 16,
    parameter int GAP_MULT = 4
) (
    input  logic            i_clk,
    input  logic            i_arst_n,
    input  logic            i_tick,
    input  logic            i_load,
`ifdef LED_PATTERN_SYNC_EN
    input  logic            i_sync,
`endif
    input  logic [1:0]      i_mode,
    input  logic [HP_W-1:0] i_half_period,
    input  logic [3:0]      i_burst_cnt,
    output logic            o_led
);

    // Three extra bits so GAP_MULT*half_period fits for GAP_MULT up to 8.
    localparam int PH_W = HP_W + 3;
    localparam logic [PH_W-1:0] GAP_K = PH_W'(GAP_MULT);

    led_state_t      state, state_nxt;
    logic [PH_W-1:0] ph, ph_nxt;
    logic [3:0]      pulses, pulses_nxt;
    logic [HP_W-1:0] hp, hp_nxt;
    logic [3:0]      bcnt, bcnt_nxt;
    logic            led_nxt;

    logic [PH_W-1:0] ph_last;
    logic [PH_W-1:0] gap_last;
    logic            ph_end;
    logic            gap_end;

    // hp is never 0 after load, so these terminal counts never wrap.
    assign ph_last  = {3'b000, hp} - PH_W'(1);
    assign gap_last = (GAP_K * {3'b000, hp}) - PH_W'(1);
    assign ph_end   = (ph == ph_last);
    assign gap_end  = (ph == gap_last);

    // State, config and counter registers; o_led is registered from the next state.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state  <= S_OFF;
            ph     <= '0;
            pulses <= '0;
            hp     <= HP_W'(1);
            bcnt   <= '0;
            o_led  <= 1'b0;
        end else begin
            state  <= state_nxt;
            ph     <= ph_nxt;
            pulses <= pulses_nxt;
            hp     <= hp_nxt;
            bcnt   <= bcnt_nxt;
            o_led  <= led_nxt;
        end
    end

    // Next-state logic: load beats sync, sync beats the tick.
    always_comb begin
        state_nxt  = state;
        ph_nxt     = ph;
        pulses_nxt = pulses;
        hp_nxt     = hp;
        bcnt_nxt   = bcnt;

        if (i_load) begin
            hp_nxt     = (i_half_period == '0) ? HP_W'(1) : i_half_period;
            bcnt_nxt   = i_burst_cnt;
            ph_nxt     = '0;
            pulses_nxt = '0;
            case (led_mode_t'(i_mode))
                MODE_ON:    state_nxt = S_ON;
                MODE_BLINK: state_nxt = S_HI;
                MODE_BURST: state_nxt = (i_burst_cnt == 4'd0) ? S_OFF : S_BHI;
                default:    state_nxt = S_OFF;
            endcase
`ifdef LED_PATTERN_SYNC_EN
        end else if (i_sync) begin
            case (state)
                S_HI, S_LO: begin
                    state_nxt = S_HI;
                    ph_nxt    = '0;
                end
                S_BHI, S_BLO, S_GAP: begin
                    state_nxt  = S_BHI;
                    ph_nxt     = '0;
                    pulses_nxt = '0;
                end
                default: ;
            endcase
`endif
        end else if (i_tick) begin
            case (state)
                S_HI: begin
                    if (ph_end) begin
                        state_nxt = S_LO;
                        ph_nxt    = '0;
                    end else begin
                        ph_nxt = ph + PH_W'(1);
                    end
                end
                S_LO: begin
                    if (ph_end) begin
                        state_nxt = S_HI;
                        ph_nxt    = '0;
                    end else begin
                        ph_nxt = ph + PH_W'(1);
                    end
                end
                S_BHI: begin
                    if (ph_end) begin
                        state_nxt  = S_BLO;
                        ph_nxt     = '0;
                        pulses_nxt = pulses + 4'd1;
                    end else begin
                        ph_nxt = ph + PH_W'(1);
                    end
                end
                S_BLO: begin
                    if (ph_end) begin
                        state_nxt = (pulses == bcnt) ? S_GAP : S_BHI;
                        ph_nxt    = '0;
                    end else begin
                        ph_nxt = ph + PH_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        state_nxt  = S_BHI;
                        ph_nxt     = '0;
                        pulses_nxt = '0;
                    end else begin
                        ph_nxt = ph + PH_W'(1);
                    end
                end
                default: ;
            endcase
        end

        led_nxt = (state_nxt == S_ON) || (state_nxt == S_HI) || (state_nxt == S_BHI);
    end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - multi-channel LED pattern generator top: prescaler, sync fan-out, channel array (optional LED_PATTERN_SYNC_EN)
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int CLK_VALUE = 100000000,
    parameter int TICK_HZ   = 1000,
    parameter int CHANNELS  = 4,
    parameter int HP_W      = 16,
    parameter int GAP_MULT  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
`ifdef LED_PATTERN_SYNC_EN
    input  logic                     i_sync,
`endif
    input  logic [CHANNELS-1:0]      i_cfg_load,
    input  logic [2*CHANNELS-1:0]    i_mode,
    input  logic [HP_W*CHANNELS-1:0] i_half_period,
    input  logic [4*CHANNELS-1:0]    i_burst_cnt,
    output logic [CHANNELS-1:0]      o_led,
    output logic                     o_tick
);

    // DIV must be at least 2 so the tick is a single-cycle pulse.
    localparam int DIV   = calc_div(CLK_VALUE, TICK_HZ);
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Shared prescaler counting 0..DIV-1; a sync pulse realigns it to 0.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            cnt <= '0;
`ifdef LED_PATTERN_SYNC_EN
        end else if (i_sync) begin
            cnt <= '0;
`endif
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign o_tick = (cnt == CNT_LAST);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        led_pattern_channel #(
            .HP_W     (HP_W),
            .GAP_MULT (GAP_MULT)
        ) u_ch (
            .i_clk         (i_clk),
            .i_arst_n      (i_arst_n),
            .i_tick        (o_tick),
            .i_load        (i_cfg_load[g]),
`ifdef LED_PATTERN_SYNC_EN
            .i_sync        (i_sync),
`endif
            .i_mode        (i_mode[2*g +: 2]),
            .i_half_period (i_half_period[HP_W*g +: HP_W]),
            .i_burst_cnt   (i_burst_cnt[4*g +: 4]),
            .o_led         (o_led[g])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - scoreboard testbench for led_pattern_gen (LED_PATTERN_SYNC_EN adds the sync scenario)
module tb_led_pattern_gen;

    localparam int CLK_VALUE = 1000;
    localparam int TICK_HZ   = 100;
    localparam int CHANNELS  = 4;
    localparam int HP_W      = 16;
    localparam int GAP_MULT  = 4;
    localparam int DIV       = 10;

    logic                     clk      = 1'b0;
    logic                     rst_n    = 1'b0;
    logic [CHANNELS-1:0]      cfg_load = '0;
    logic [2*CHANNELS-1:0]    mode     = '0;
    logic [HP_W*CHANNELS-1:0] hp       = '0;
    logic [4*CHANNELS-1:0]    bc       = '0;
    logic [CHANNELS-1:0]      led;
    logic                     tick;
`ifdef LED_PATTERN_SYNC_EN
    logic                     sync     = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    led_pattern_gen #(
        .CLK_VALUE (CLK_VALUE),
        .TICK_HZ   (TICK_HZ),
        .CHANNELS  (CHANNELS),
        .HP_W      (HP_W),
        .GAP_MULT  (GAP_MULT)
    ) dut (
        .i_clk         (clk),
        .i_arst_n      (rst_n),
`ifdef LED_PATTERN_SYNC_EN
        .i_sync        (sync),
`endif
        .i_cfg_load    (cfg_load),
        .i_mode        (mode),
        .i_half_period (hp),
        .i_burst_cnt   (bc),
        .o_led         (led),
        .o_tick        (tick)
    );

    always #5 clk = ~clk;

    // Reference model: counts ticks seen by each channel since its last restart
    // and derives the LED level arithmetically from that count.
    int m_cnt;
    int m_mode [CHANNELS];
    int m_hp   [CHANNELS];
    int m_bc   [CHANNELS];
    int m_t    [CHANNELS];
    logic [CHANNELS:0] sb_q [$];

    function automatic logic model_led(input int md, input int h, input int b, input int t);
        int seg;
        case (md)
            1: return 1'b1;
            2: return ((t / h) % 2) == 0;
            3: begin
                seg = (t % ((2 * b + GAP_MULT) * h)) / h;
                return (seg < 2 * b) && ((seg % 2) == 0);
            end
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit tk;
        bit syn;
        int h;
        logic [CHANNELS-1:0] e;
        syn = 1'b0;
`ifdef LED_PATTERN_SYNC_EN
        syn = sync;
`endif
        if (!rst_n) begin
            m_cnt = 0;
            for (int c = 0; c < CHANNELS; c++) begin
                m_mode[c] = 0; m_hp[c] = 1; m_bc[c] = 0; m_t[c] = 0;
            end
        end else begin
            tk = (m_cnt == DIV - 1);
            m_cnt = (tk || syn) ? 0 : m_cnt + 1;
            for (int c = 0; c < CHANNELS; c++) begin
                if (cfg_load[c]) begin
                    h = int'(hp[HP_W*c +: HP_W]);
                    m_hp[c]   = (h == 0) ? 1 : h;
                    m_bc[c]   = int'(bc[4*c +: 4]);
                    m_mode[c] = int'(mode[2*c +: 2]);
                    if (m_mode[c] == 3 && m_bc[c] == 0) m_mode[c] = 0;
                    m_t[c] = 0;
                end else if (syn && m_mode[c] >= 2) begin
                    m_t[c] = 0;
                end else if (tk) begin
                    m_t[c] = m_t[c] + 1;
                end
            end
        end
        for (int c = 0; c < CHANNELS; c++)
            e[c] = model_led(m_mode[c], m_hp[c], m_bc[c], m_t[c]);
        sb_q.push_back({(rst_n && m_cnt == DIV - 1), e});
    end

    logic [CHANNELS:0] exp_v;

    // Advance to the next falling edge and pop the expectation for that cycle.
    task automatic step();
        @(negedge clk);
        if (sb_q.size() == 0) exp_v = 'x;
        else exp_v = sb_q.pop_front();
    endtask

    task automatic cfg(input int ch, input int md, input int h, input int b);
        mode[2*ch +: 2]     = md[1:0];
        hp[HP_W*ch +: HP_W] = h[HP_W-1:0];
        bc[4*ch +: 4]       = b[3:0];
        cfg_load[ch]        = 1'b1;
    endtask

    task automatic test_reset();
        int first_tick;
        int n_ticks;
        rst_n = 1'b0;
        repeat (3) step();
        n_chk++;
        if (led !== 4'b0000 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state led=%b tick=%b required led=0000 tick=0", led, tick);
        end
        rst_n = 1'b1;
        first_tick = -1;
        n_ticks = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            n_chk++;
            if ({tick, led} !== exp_v) begin
                n_fail++;
                $display("FAIL free_run cyc=%0d got=%b required=%b", k, {tick, led}, exp_v);
            end
            if (tick === 1'b1) begin
                n_ticks++;
                if (first_tick < 0) first_tick = k;
            end
        end
        n_chk++;
        if (first_tick != 9) begin
            n_fail++;
            $display("FAIL first_tick got=%0d required=9", first_tick);
        end
        n_chk++;
        if (n_ticks != 10) begin
            n_fail++;
            $display("FAIL tick_count got=%0d required=10", n_ticks);
        end
    endtask

    task automatic test_on_off();
        cfg(0, 1, 5, 0);
        cfg(1, 0, 5, 0);
        step();
        cfg_load = '0;
        n_chk++;
        if (led[0] !== 1'b1 || led[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL on_off_latency led[1:0]=%b required=01", led[1:0]);
        end
        for (int k = 0; k < 20; k++) begin
            step();
            n_chk++;
            if ({tick, led} !== exp_v) begin
                n_fail++;
                $display("FAIL on_off cyc=%0d got=%b required=%b", k, {tick, led}, exp_v);
            end
        end
    endtask

    task automatic test_blink();
        int edges [$];
        logic prev;
        cfg(2, 2, 3, 0);
        step();
        cfg_load = '0;
        prev = led[2];
        for (int k = 0; k < 160; k++) begin
            step();
            n_chk++;
            if ({tick, led} !== exp_v) begin
                n_fail++;
                $display("FAIL blink cyc=%0d got=%b required=%b", k, {tick, led}, exp_v);
            end
            if (led[2] !== prev) edges.push_back(k);
            prev = led[2];
        end
        n_chk++;
        if (edges.size() < 4) begin
            n_fail++;
            $display("FAIL blink_edges got=%0d required>=4", edges.size());
        end
        for (int i = 1; i < edges.size(); i++) begin
            n_chk++;
            if (edges[i] - edges[i-1] != 30) begin
                n_fail++;
                $display("FAIL blink_half got=%0d required=30", edges[i] - edges[i-1]);
            end
        end
    endtask

    task automatic test_load_on_tick();
        int fall;
        int waited;
        waited = 0;
        step();
        while (tick !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        n_chk++;
        if (tick !== 1'b1) begin
            n_fail++;
            $display("FAIL tick_wait got=%b required=1", tick);
        end
        cfg(1, 2, 0, 0);
        step();
        cfg_load = '0;
        fall = -1;
        for (int k = 1; k <= 60; k++) begin
            step();
            n_chk++;
            if ({tick, led} !== exp_v) begin
                n_fail++;
                $display("FAIL load_on_tick cyc=%0d got=%b required=%b", k, {tick, led}, exp_v);
            end
            if (fall < 0 && led[1] === 1'b0) fall = k;
        end
        n_chk++;
        if (fall != 10) begin
            n_fail++;
            $display("FAIL hp0_first_fall got=%0d required=10", fall);
        end
    endtask

    task automatic test_burst();
        cfg(3, 3, 1, 2);
        step();
        cfg_load = '0;
        for (int k = 0; k < 200; k++) begin
            step();
            n_chk++;
            if ({tick, led} !== exp_v) begin
                n_fail++;
                $display("FAIL burst cyc=%0d got=%b required=%b", k, {tick, led}, exp_v);
            end
        end
        cfg(3, 3, 1, 0);
        step();
        cfg_load = '0;
        for (int k = 0; k < 50; k++) begin
            step();
            n_chk++;
            if (led[3] !== 1'b0 || {tick, led} !== exp_v) begin
                n_fail++;
                $display("FAIL burst_zero cyc=%0d got=%b required=%b", k, {tick, led}, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        cfg(0, 2, 2, 0);
        step();
        cfg_load = '0;
        cfg(0, 3, 2, 3);
        cfg(3, 2, 1, 0);
        step();
        cfg_load = '0;
        cfg(1, 1, 0, 0);
        step();
        cfg_load = '0;
        for (int k = 0; k < 250; k++) begin
            step();
            n_chk++;
            if ({tick, led} !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back cyc=%0d got=%b required=%b", k, {tick, led}, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        waited = 0;
        step();
        while (led[2] !== 1'b1 && waited < 80) begin
            step();
            waited++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (led !== 4'b0000 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset led=%b tick=%b required led=0000 tick=0", led, tick);
        end
        repeat (2) step();
        rst_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            step();
            n_chk++;
            if (led !== 4'b0000 || {tick, led} !== exp_v) begin
                n_fail++;
                $display("FAIL post_reset cyc=%0d got=%b required=%b", k, {tick, led}, exp_v);
            end
        end
    endtask

`ifdef LED_PATTERN_SYNC_EN
    task automatic test_sync();
        cfg(0, 2, 2, 0);
        step();
        cfg_load = '0;
        repeat (14) step();
        cfg(1, 2, 2, 0);
        step();
        cfg_load = '0;
        repeat (7) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int k = 0; k < 120; k++) begin
            step();
            n_chk++;
            if (led[0] !== led[1] || {tick, led} !== exp_v) begin
                n_fail++;
                $display("FAIL sync cyc=%0d got=%b required=%b", k, {tick, led}, exp_v);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_on_off();
        test_blink();
        test_load_on_tick();
        test_burst();
        test_back_to_back();
        test_reset_mid();
`ifdef LED_PATTERN_SYNC_EN
        test_sync();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Multi-channel LED pattern generator for board status indication: the parametrised successor to the single-output heartbeat blinker. A shared prescaler derives a slow tick from the system clock. Each of `CHANNELS` outputs then runs an independent pattern (off, on, blink, burst-blink) configured at run time. It sits in the top level next to the block design, clocked by the PCIe AXI clock, and drives the link, heartbeat and error LEDs.

## Interface
- `CLK_VALUE`, 100000000, input clock frequency in Hz
- `TICK_HZ`, 1000, pattern tick rate; `DIV = CLK_VALUE / TICK_HZ`, must be ≥ 2
- `CHANNELS`, 4, number of LED outputs, 1..16
- `HP_W`, 16, width of the half-period field, in ticks
- `GAP_MULT`, 4, burst gap length in half-periods
- `i_clk` input 1 system clock
- `i_arst_n` input 1 asynchronous active-low reset
- `i_cfg_load` input CHANNELS per-channel config strobe, one-cycle pulse
- `i_mode` input 2*CHANNELS per-channel mode: 00 OFF, 01 ON, 10 BLINK, 11 BURST
- `i_half_period` input HP_W*CHANNELS per-channel half-period in ticks
- `i_burst_cnt` input 4*CHANNELS per-channel pulses per burst
- `o_led` output CHANNELS LED drive, registered
- `o_tick` output 1 prescaler tick, one-cycle pulse

## Operation
- Prescaler: `cnt` counts 0..DIV-1 and wraps. `o_tick`=1 in the cycle where `cnt`==DIV-1.
- Each channel latches mode, half-period and burst count when its `i_cfg_load` bit is 1. Unloaded channels keep their current state and phase.
- Latched half-period 0 is treated as 1.
- Latched burst count 0 is treated as OFF.
- Per-channel FSM states: S_OFF, S_ON, S_HI, S_LO, S_BHI, S_BLO, S_GAP. The phase counter `ph` runs in ticks.
- On load, the channel enters the start state for its mode and clears `ph`:
  - OFF → S_OFF
  - ON → S_ON
  - BLINK → S_HI
  - BURST → S_BHI with `pulses`=0
- S_HI ↔ S_LO: toggle when `ph`==half_period-1 on a tick, then clear `ph`.
- S_BHI → S_BLO after half_period ticks; `pulses` increments on this transition.
- From S_BLO after half_period ticks:
  - if `pulses`==burst_cnt, go to S_GAP;
  - otherwise return to S_BHI.
- S_GAP → S_BHI after GAP_MULT*half_period ticks, with `pulses` cleared.
- `o_led`=1 in S_ON, S_HI and S_BHI; 0 otherwise.
- Load coincident with a tick: the load wins and that tick is not counted for the channel.

## Timing
- Reset values: `o_led`=0, `o_tick`=0, prescaler 0, every channel in S_OFF with `ph`=0 and `pulses`=0.
- Config latency: `o_led` reflects the new mode in the cycle after `i_cfg_load`.
- Pattern edges: `o_led` changes in the cycle after the tick that completes the phase.
- Blink period: exactly 2*half_period ticks = 2*half_period*DIV clocks.
- Burst cycle: (2*burst_cnt + GAP_MULT)*half_period ticks.
- `ph` is HP_W+3 bits wide. The gap count must not overflow for GAP_MULT ≤ 8.
- Reset mid-pattern: all outputs go low asynchronously. After release, the prescaler restarts from 0.

## Configuration
- `LED_PATTERN_SYNC_EN` defined:
  - adds port `i_sync` (input, 1 bit).
  - A pulse restarts every channel in BLINK or BURST at its start state with `ph`=0, one cycle later. This gives phase-aligned LEDs.
  - The prescaler is also cleared.
  - `i_sync` coincident with `i_cfg_load` on a channel: the load takes priority for that channel.
- Not defined: no `i_sync` port and no sync logic. Channels stay phase-independent.

## Structure
- `led_pattern_pkg` contains:
  - `led_mode_t` enum, 2 bits;
  - `led_state_t` enum;
  - a `calc_div(CLK_VALUE, TICK_HZ)` function.
- Sub-module `led_pattern_channel`: one channel's FSM, config registers and counters, instantiated CHANNELS times in a generate loop.
- The top contains the prescaler and the sync distribution.

## Test plan
All scenarios use CLK_VALUE=1000, TICK_HZ=100, so DIV=10.
- Reset, then free-run 100 clocks → `o_tick` pulses every 10 clocks, first at clock 9; all `o_led`=0.
- Ch0 load ON, ch1 load OFF → `o_led[0]`=1 one cycle after load; `o_led[1]` stays 0.
- Ch2 BLINK with half_period=3 → high for 30 clocks and low for 30, repeating; first edge at the third tick after load.
- Ch3 BURST with half_period=1, burst_cnt=2, GAP_MULT=4 → pattern H,L,H,L then 4 ticks low, repeating every 8 ticks. Burst_cnt=0 → LED held low.
- Assert `i_arst_n` low mid-blink → `o_led`=0 immediately; after release every channel is OFF until reloaded.
- With `LED_PATTERN_SYNC_EN`: ch0 BLINK with half_period=2, ch1 BLINK with half_period=2 loaded 15 clocks later, then `i_sync` → both LEDs toggle on identical cycles.
